run_sequencer: RTL and testbench

Program-counter and run-control stage sitting directly upstream of instruction fetch in the 9-bit single-cycle core. Owns the PC register, sequences the testbench start/done handshake (idle, armed, run, finished), and applies sequential or branch-relative next-PC updates from the decoder's branch and halt outputs. Drives the fetch address and a run enable that gates all architectural writes in the datapath.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/run_sequencer.sv | 110 +++++++++++
 tb/tb_run_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit core: run-control states and address/offset widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    RUN      = 2'd2,
    FINISHED = 2'd3
  } state_t;

  localparam int PC_W_DEFAULT = 10;
  localparam int OFFSET_W     = 8;

endpackage : cpu_pkg

// File: rtl/run_sequencer.sv
// PC register and start/done run control feeding instruction fetch; run_en gates
// every architectural write in the datapath.
module run_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CYC_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt,
  input  logic                branch_taken,
  input  logic [OFFSET_W-1:0] branch_offset,
  output logic [PC_W-1:0]     pc,
  output logic                run_en,
  output logic                done,
  output logic [CYC_W-1:0]    cycle_count
);

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_next;
  logic [CYC_W-1:0] r_cnt;
  logic [CYC_W-1:0] w_cnt_next;

  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W:0]    w_offset_ext;
  logic [PC_W:0]    w_branch_sum;
  logic [PC_W-1:0]  w_pc_branch;
  logic [CYC_W-1:0] w_cnt_sat_inc;

  // Branch target is relative to pc+1; the carry bit is dropped so targets wrap.
  assign w_pc_inc      = r_pc + PC_ONE;
  assign w_offset_ext  = {{(PC_W+1-OFFSET_W){branch_offset[OFFSET_W-1]}}, branch_offset};
  assign w_branch_sum  = {1'b0, w_pc_inc} + w_offset_ext;
  assign w_pc_branch   = w_branch_sum[PC_W-1:0];
  assign w_cnt_sat_inc = (r_cnt == CYC_MAX) ? r_cnt : (r_cnt + CYC_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        w_pc_next  = '0;
        w_cnt_next = '0;
        if (start) begin
          w_state_next = ARMED;
        end
      end
      ARMED: begin
        w_pc_next  = '0;
        w_cnt_next = '0;
        if (!start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        // The halting instruction still counts as an executed cycle.
        w_cnt_next = w_cnt_sat_inc;
        if (halt) begin
          w_state_next = FINISHED;
        end else if (branch_taken) begin
          w_pc_next = w_pc_branch;
        end else begin
          w_pc_next = w_pc_inc;
        end
      end
      FINISHED: begin
        if (start) begin
          w_state_next = ARMED;
          w_pc_next    = '0;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_pc_next    = '0;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    run_en = (r_state == RUN);
    done   = (r_state == FINISHED);
  end

  assign pc          = r_pc;
  assign cycle_count = r_cnt;

endmodule : run_sequencer

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: a main instance (CYC_W=16) and a narrow-counter
// instance (CYC_W=4) share all inputs so counter saturation is seen alongside the PC flow.
module tb_run_sequencer;

  localparam int S_IDLE = 0;
  localparam int S_ARMED = 1;
  localparam int S_RUN = 2;
  localparam int S_FIN = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt;
  logic        branch_taken;
  logic [7:0]  branch_offset;
  logic [9:0]  pc;
  logic        run_en;
  logic        done;
  logic [15:0] cycle_count;
  logic [9:0]  pc4;
  logic        run_en4;
  logic        done4;
  logic [3:0]  cycle_count4;

  run_sequencer #(.PC_W(10), .CYC_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc), .run_en(run_en), .done(done), .cycle_count(cycle_count)
  );

  run_sequencer #(.PC_W(10), .CYC_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc4), .run_en(run_en4), .done(done4), .cycle_count(cycle_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int run_en;
    int done;
    int cnt;
    int cnt4;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  int m_state = S_IDLE;
  int m_pc = 0;
  int m_cnt = 0;
  int m_cnt4 = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare after the edge.
  task automatic step(input logic rst, input logic s, input logic h, input logic bt,
                      input logic [7:0] off);
    int ns, npc, ncnt, ncnt4, raw;
    exp_t e;
    reset = rst; start = s; halt = h; branch_taken = bt; branch_offset = off;
    ns = m_state; npc = m_pc; ncnt = m_cnt; ncnt4 = m_cnt4;
    if (rst) begin
      ns = S_IDLE; npc = 0; ncnt = 0; ncnt4 = 0;
    end else begin
      case (m_state)
        S_IDLE:  begin ns = s ? S_ARMED : S_IDLE; npc = 0; ncnt = 0; ncnt4 = 0; end
        S_ARMED: begin ns = s ? S_ARMED : S_RUN;  npc = 0; ncnt = 0; ncnt4 = 0; end
        S_RUN: begin
          ncnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
          ncnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
          if (h) begin
            ns = S_FIN;
          end else begin
            raw = m_pc + 1 + (bt ? int'($signed(off)) : 0);
            npc = ((raw % 1024) + 1024) % 1024;
          end
        end
        default: begin
          if (s) begin ns = S_ARMED; npc = 0; ncnt = 0; ncnt4 = 0; end
        end
      endcase
    end
    e.pc = npc; e.run_en = (ns == S_RUN); e.done = (ns == S_FIN);
    e.cnt = ncnt; e.cnt4 = ncnt4;
    sb_q.push_back(e);
    m_state = ns; m_pc = npc; m_cnt = ncnt; m_cnt4 = ncnt4;

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("sb_pc", pc, e.pc);
      check("sb_run_en", run_en, e.run_en);
      check("sb_done", done, e.done);
      check("sb_cnt", cycle_count, e.cnt);
      check("sb_cnt4", cycle_count4, e.cnt4);
      check("sb_pc4", pc4, e.pc);
    end
  endtask

  task automatic run_plain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic start_pulse();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; branch_taken = 1'b0; branch_offset = 8'h00;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_pc", pc, 0);
    check("rst_run_en", run_en, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cycle_count, 0);

    // Single-cycle start pulse: first RUN cycle fetches pc=0
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    start_pulse();
    check("run_first_pc", pc, 0);
    check("run_first_en", run_en, 1);
    run_plain(1);
    check("run_pc1", pc, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);  // start ignored in RUN
    check("run_pc2", pc, 2);
    check("run_done_low", done, 0);

    // Backward branch past address 0
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hF0);
    check("br_wrap_low", pc, 1011);
    run_plain(12);
    check("pc_1023", pc, 1023);
    run_plain(1);
    check("pc_wrap_top", pc, 0);

    // Relative branches at pc=5
    run_plain(5);
    check("pc_5a", pc, 5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFD);
    check("br_back", pc, 3);
    run_plain(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h04);
    check("br_fwd", pc, 10);
    run_plain(2);
    check("pc_12", pc, 12);
    check("cnt4_sat", cycle_count4, 15);
    check("cnt_big", cycle_count, m_cnt);

    // Reset mid-RUN
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("midrst_pc", pc, 0);
    check("midrst_done", done, 0);
    check("midrst_cnt", cycle_count, 0);
    check("midrst_run_en", run_en, 0);

    // Halt together with a taken branch after 8 RUN cycles
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    start_pulse();
    run_plain(7);
    check("pc_7", pc, 7);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h04);
    check("halt_pc", pc, 7);
    check("halt_done", done, 1);
    check("halt_run_en", run_en, 0);
    check("halt_cnt", cycle_count, 8);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h10);
    check("fin_hold_pc", pc, 7);
    check("fin_hold_cnt", cycle_count, 8);

    // Re-launch from FINISHED, start held high for two cycles
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("rearm_pc", pc, 0);
    check("rearm_cnt", cycle_count, 0);
    check("rearm_done", done, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("relaunch_run_en", run_en, 1);
    run_plain(3);
    check("relaunch_pc", pc, 3);
    check("relaunch_cnt", cycle_count, 3);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_run_sequencer
